// File: rtl/temp_sched_pkg.sv
// Shared types and helpers for the DS18B20 measurement scheduler.
package temp_sched_pkg;

  localparam int TEMP_W = 12;
  localparam int SUM_W  = 14;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    SETTLE  = 2'd2,
    CAPTURE = 2'd3
  } state_e;

  // Negative zero maps to 0 because -0 == 0 in two's complement.
  function automatic logic signed [TEMP_W-1:0] sm_to_s(input logic sign,
                                                       input logic [10:0] mag);
    logic signed [TEMP_W-1:0] m;
    m = $signed({1'b0, mag});
    return sign ? -m : m;
  endfunction

endpackage

// File: rtl/temp_hyst_cmp.sv
// Registered set/clear hysteresis comparator; HI_POL selects high-alarm (1) or
// low-alarm (0) polarity. Evaluated only when en is asserted.
module temp_hyst_cmp
  import temp_sched_pkg::*;
#(
  parameter bit                         HI_POL = 1'b1,
  parameter logic signed [TEMP_W-1:0]   TH     = '0,
  parameter logic        [TEMP_W-1:0]   HYST   = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic signed [TEMP_W-1:0] val,
  output logic                     alarm
);

  // Widened so TH +/- HYST cannot wrap.
  localparam logic signed [SUM_W-1:0] TH_X   = SUM_W'(TH);
  localparam logic signed [SUM_W-1:0] HYST_X = SUM_W'(HYST);
  localparam logic signed [SUM_W-1:0] REL_X  = HI_POL ? (TH_X - HYST_X) : (TH_X + HYST_X);

  logic signed [SUM_W-1:0] val_x;
  logic                    set_c;
  logic                    clr_c;
  logic                    alarm_q;
  logic                    alarm_d;

  always_comb begin
    val_x = SUM_W'(val);
    if (HI_POL) begin
      set_c = (val_x >= TH_X);
      clr_c = (val_x <  REL_X);
    end else begin
      set_c = (val_x <= TH_X);
      clr_c = (val_x >  REL_X);
    end
    alarm_d = alarm_q;
    if (en && set_c) begin
      alarm_d = 1'b1;
    end else if (en && clr_c) begin
      alarm_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= alarm_d;
    end
  end

  assign alarm = alarm_q;

endmodule

// File: rtl/temp_sched.sv
// DS18B20 one-shot measurement scheduler with settle detection and hysteresis alarms.
// Define TEMP_SCHED_AVG_EN to report the mean of the last four samples on temp_q.
module temp_sched
  import temp_sched_pkg::*;
#(
  parameter int                       PERIOD_CYC  = 24_000_000,
  parameter int                       WINDOW_CYC  = 7_200_000,
  parameter int                       STABLE_CYC  = 64,
  parameter int                       TIMEOUT_CYC = 2_400_000,
  parameter logic signed [TEMP_W-1:0] TH_HI       = 12'sd1200,
  parameter logic signed [TEMP_W-1:0] TH_LO       = -12'sd160,
  parameter logic        [TEMP_W-1:0] HYST        = 12'd32
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     drv_rst_n,
  input  logic [15:0]              temp_data,
  input  logic                     req,
  output logic                     req_ack,
  output logic                     busy,
  output logic signed [TEMP_W-1:0] temp_q,
  output logic                     temp_valid,
  output logic                     alarm_hi,
  output logic                     alarm_lo,
  output logic                     err
);

  localparam int CNT_MAX = (PERIOD_CYC > WINDOW_CYC)
                         ? ((PERIOD_CYC > TIMEOUT_CYC) ? PERIOD_CYC : TIMEOUT_CYC)
                         : ((WINDOW_CYC > TIMEOUT_CYC) ? WINDOW_CYC : TIMEOUT_CYC);
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int STB_W = $clog2(STABLE_CYC + 1);

  localparam logic [CNT_W-1:0] PERIOD_LAST  = CNT_W'(PERIOD_CYC - 1);
  localparam logic [CNT_W-1:0] WINDOW_LAST  = CNT_W'(WINDOW_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [STB_W-1:0] STABLE_LAST  = STB_W'(STABLE_CYC - 1);

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [STB_W-1:0]         stab_q, stab_d;
  logic [15:0]              prev_q, prev_d;
  logic                     prev_vld_q, prev_vld_d;
  logic                     req_ack_q, req_ack_d;
  logic                     temp_valid_q, temp_valid_d;
  logic                     err_q, err_d;
  logic signed [TEMP_W-1:0] sample_q, sample_d;
  logic                     capture;
  logic signed [TEMP_W-1:0] conv_s;
  logic signed [TEMP_W-1:0] new_val;

  // One counter serves as period, window and timeout counter; it clears on every state change.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    stab_d       = '0;
    prev_d       = prev_q;
    prev_vld_d   = 1'b0;
    req_ack_d    = 1'b0;
    temp_valid_d = 1'b0;
    err_d        = err_q;
    capture      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req || (cnt_q == PERIOD_LAST)) begin
          state_d   = RUN;
          cnt_d     = '0;
          req_ack_d = req;
        end
      end
      RUN: begin
        if (cnt_q == WINDOW_LAST) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        // First SETTLE cycle has no valid previous word, so it never counts as a match.
        prev_vld_d = 1'b1;
        if (prev_vld_q && (temp_data == prev_q)) begin
          stab_d = stab_q + 1'b1;
        end
        if (stab_q == STABLE_LAST) begin
          state_d = CAPTURE;
          cnt_d   = '0;
        end else begin
          prev_d = temp_data;
          if (cnt_q == TIMEOUT_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            err_d   = 1'b1;
          end
        end
      end
      CAPTURE: begin
        state_d      = IDLE;
        cnt_d        = '0;
        capture      = 1'b1;
        temp_valid_d = 1'b1;
        err_d        = 1'b0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign conv_s = sm_to_s(prev_q[15], prev_q[10:0]);

`ifdef TEMP_SCHED_AVG_EN
  logic signed [TEMP_W-1:0] avg_buf_q [4];
  logic signed [TEMP_W-1:0] avg_buf_d [4];
  logic                     primed_q, primed_d;
  logic signed [SUM_W-1:0]  avg_sum;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      avg_buf_d[i] = avg_buf_q[i];
    end
    primed_d = primed_q;
    if (capture) begin
      primed_d = 1'b1;
      if (!primed_q) begin
        for (int i = 0; i < 4; i++) begin
          avg_buf_d[i] = conv_s;
        end
      end else begin
        avg_buf_d[0] = conv_s;
        for (int i = 1; i < 4; i++) begin
          avg_buf_d[i] = avg_buf_q[i-1];
        end
      end
    end
    avg_sum = '0;
    for (int i = 0; i < 4; i++) begin
      avg_sum = avg_sum + SUM_W'(avg_buf_d[i]);
    end
    new_val = TEMP_W'(avg_sum >>> 2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      primed_q <= 1'b0;
    end else begin
      primed_q <= primed_d;
    end
  end

  always_ff @(posedge clk) begin
    avg_buf_q <= avg_buf_d;
  end
`else
  assign new_val = conv_s;
`endif

  always_comb begin
    sample_d = sample_q;
    if (capture) begin
      sample_d = new_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      stab_q       <= '0;
      prev_vld_q   <= 1'b0;
      req_ack_q    <= 1'b0;
      temp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      sample_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      stab_q       <= stab_d;
      prev_vld_q   <= prev_vld_d;
      req_ack_q    <= req_ack_d;
      temp_valid_q <= temp_valid_d;
      err_q        <= err_d;
      sample_q     <= sample_d;
    end
  end

  always_ff @(posedge clk) begin
    prev_q <= prev_d;
  end

  temp_hyst_cmp #(
    .HI_POL (1'b1),
    .TH     (TH_HI),
    .HYST   (HYST)
  ) u_alarm_hi (
    .clk   (clk),
    .rst   (rst),
    .en    (capture),
    .val   (new_val),
    .alarm (alarm_hi)
  );

  temp_hyst_cmp #(
    .HI_POL (1'b0),
    .TH     (TH_LO),
    .HYST   (HYST)
  ) u_alarm_lo (
    .clk   (clk),
    .rst   (rst),
    .en    (capture),
    .val   (new_val),
    .alarm (alarm_lo)
  );

  assign drv_rst_n  = (state_q != IDLE);
  assign busy       = (state_q != IDLE);
  assign req_ack    = req_ack_q;
  assign temp_valid = temp_valid_q;
  assign temp_q     = sample_q;
  assign err        = err_q;

endmodule

// File: tb/tb_temp_sched.sv
// Randomized bench for temp_sched against a duration-based behavioural model.
`timescale 1ns/1ps
module tb_temp_sched;

  localparam int P      = 100;
  localparam int W      = 50;
  localparam int S      = 4;
  localparam int T      = 40;
  localparam int NPLAN  = 30;
  localparam int MID    = 14;
  localparam int BUDGET = 60000;
  localparam int NOLIT  = -9999;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               drv_rst_n;
  logic [15:0]        temp_data = 16'h0000;
  logic               req = 1'b0;
  logic               req_ack;
  logic               busy;
  logic signed [11:0] temp_q;
  logic               temp_valid;
  logic               alarm_hi;
  logic               alarm_lo;
  logic               err;

  always #5 clk = ~clk;

  temp_sched #(
    .PERIOD_CYC  (P),
    .WINDOW_CYC  (W),
    .STABLE_CYC  (S),
    .TIMEOUT_CYC (T)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .drv_rst_n  (drv_rst_n),
    .temp_data  (temp_data),
    .req        (req),
    .req_ack    (req_ack),
    .busy       (busy),
    .temp_q     (temp_q),
    .temp_valid (temp_valid),
    .alarm_hi   (alarm_hi),
    .alarm_lo   (alarm_lo),
    .err        (err)
  );

  int checks   = 0;
  int failures = 0;

  // Sample plan: one entry per measurement the scheduler will start.
  logic [15:0] p_val      [NPLAN];
  bit          p_bad      [NPLAN];
  int          p_req_at   [NPLAN];
  bit          p_req_busy [NPLAN];

  int lit_q  [8];
  int lit_hi [8];
  int lit_lo [8];
  int lit_er [8];
  int n_lit = 0;

  // Model state.
  longint cyc        = 0;
  bit     m_busy     = 1'b0;
  longint m_start    = 0;
  longint m_end      = 0;
  longint m_idle_ref = 0;
  int     m_idx      = 0;
  bit     e_ack      = 1'b0;
  bit     e_valid    = 1'b0;
  int     e_q        = 0;
  bit     e_hi       = 1'b0;
  bit     e_lo       = 1'b0;
  bit     e_err      = 1'b0;
  int     hist [$];

  bit seen_busy = 1'b0;
  int vcount    = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_drv_rst_n"}, int'(drv_rst_n), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_req_ack"}, int'(req_ack), 0);
    chk({tag, "_temp_valid"}, int'(temp_valid), 0);
    chk({tag, "_temp_q"}, int'(temp_q), 0);
    chk({tag, "_alarm_hi"}, int'(alarm_hi), 0);
    chk({tag, "_alarm_lo"}, int'(alarm_lo), 0);
    chk({tag, "_err"}, int'(err), 0);
  endtask

  task automatic add_plan(input int idx, input logic [15:0] v, input bit bad,
                          input int req_at, input bit req_busy);
    p_val[idx]      = v;
    p_bad[idx]      = bad;
    p_req_at[idx]   = req_at;
    p_req_busy[idx] = req_busy;
  endtask

  task automatic add_lit(input int q, input int hi, input int lo, input int er);
    lit_q[n_lit]  = q;
    lit_hi[n_lit] = hi;
    lit_lo[n_lit] = lo;
    lit_er[n_lit] = er;
    n_lit++;
  endtask

  // Model: a sample occupies W+S+2 cycles when data is steady, W+T when it never settles.
  initial begin : model
    int pi;
    int mag;
    int s;
    int sum;
    int k;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        cyc        = 0;
        m_busy     = 1'b0;
        m_idle_ref = 0;
        e_ack      = 1'b0;
        e_valid    = 1'b0;
        e_q        = 0;
        e_hi       = 1'b0;
        e_lo       = 1'b0;
        e_err      = 1'b0;
        hist.delete();
      end else begin
        cyc++;
        e_ack   = 1'b0;
        e_valid = 1'b0;
        pi = (m_idx < NPLAN) ? m_idx : NPLAN - 1;
        if (m_busy) begin
          if (cyc == m_end) begin
            m_busy     = 1'b0;
            m_idle_ref = cyc;
            if (p_bad[pi]) begin
              e_err = 1'b1;
            end else begin
              mag = int'(p_val[pi][10:0]);
              s   = p_val[pi][15] ? -mag : mag;
`ifdef TEMP_SCHED_AVG_EN
              if (hist.size() == 0) begin
                repeat (4) hist.push_back(s);
              end else begin
                hist.push_front(s);
                void'(hist.pop_back());
              end
              sum = 0;
              foreach (hist[j]) sum += hist[j];
              e_q = (sum >= 0) ? (sum / 4) : -((-sum + 3) / 4);
`else
              sum = 0;
              e_q = s + sum;
`endif
              if (e_q >= 1200) e_hi = 1'b1;
              else if (e_q < 1200 - 32) e_hi = 1'b0;
              if (e_q <= -160) e_lo = 1'b1;
              else if (e_q > -160 + 32) e_lo = 1'b0;
              e_valid = 1'b1;
              e_err   = 1'b0;
            end
            m_idx++;
          end
        end else begin
          k = int'(cyc - m_idle_ref - 1);
          if (req || (k == P - 1)) begin
            m_busy  = 1'b1;
            m_start = cyc;
            e_ack   = req;
            m_end   = cyc + (p_bad[pi] ? (W + T) : (W + S + 2));
          end
        end
      end
    end
  end

  // Compare process: every output, every cycle outside reset.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("drv_rst_n", int'(drv_rst_n), int'(m_busy));
        chk("busy", int'(busy), int'(m_busy));
        chk("req_ack", int'(req_ack), int'(e_ack));
        chk("temp_valid", int'(temp_valid), int'(e_valid));
        chk("temp_q", int'(temp_q), e_q);
        chk("alarm_hi", int'(alarm_hi), int'(e_hi));
        chk("alarm_lo", int'(alarm_lo), int'(e_lo));
        chk("err", int'(err), int'(e_err));
        if (!seen_busy && busy) begin
          seen_busy = 1'b1;
          chk("first_start_cycle", int'(cyc), P);
        end
        if (temp_valid) begin
          if (vcount < n_lit) begin
            if (lit_q[vcount] != NOLIT)  chk("lit_temp_q", int'(temp_q), lit_q[vcount]);
            if (lit_hi[vcount] != NOLIT) chk("lit_alarm_hi", int'(alarm_hi), lit_hi[vcount]);
            if (lit_lo[vcount] != NOLIT) chk("lit_alarm_lo", int'(alarm_lo), lit_lo[vcount]);
            if (lit_er[vcount] != NOLIT) chk("lit_err", int'(err), lit_er[vcount]);
          end
          vcount++;
        end
      end
    end
  end

  initial begin : drive
    int          n;
    int          pi;
    int          bs;
    int          guard;
    int          mag;
    bit          sign;
    logic [10:0] m11;
    bit          mid_done;

    n = 0;
`ifdef TEMP_SCHED_AVG_EN
    add_plan(n++, 16'h0064, 1'b0, -1, 1'b0);
    add_plan(n++, 16'h00C8, 1'b0, -1, 1'b0);
    add_plan(n++, 16'h012C, 1'b0, 30, 1'b0);
    add_plan(n++, 16'h0190, 1'b0, -1, 1'b0);
    add_lit(100, NOLIT, NOLIT, 0);
    add_lit(125, NOLIT, NOLIT, 0);
    add_lit(175, NOLIT, NOLIT, 0);
    add_lit(250, NOLIT, NOLIT, 0);
`else
    add_plan(n++, 16'h0190, 1'b0, -1, 1'b0);
    add_plan(n++, 16'hF8A0, 1'b0, -1, 1'b0);
    add_plan(n++, 16'h04B0, 1'b0, 30, 1'b0);
    add_plan(n++, 16'h049C, 1'b0, -1, 1'b0);
    add_plan(n++, 16'h048F, 1'b0, -1, 1'b0);
    add_lit(400, 0, 0, 0);
    add_lit(-160, 0, 1, 0);
    add_lit(1200, 1, 0, 0);
    add_lit(1180, 1, 0, 0);
    add_lit(1167, 0, 0, 0);
    add_lit(400, 0, 0, 0);
    add_lit(0, 0, 0, 0);
`endif
    add_plan(n++, 16'h0321, 1'b1, 10, 1'b1);
    add_plan(n++, 16'h0190, 1'b0, -1, 1'b0);
    add_plan(n++, 16'hF800, 1'b0, 99, 1'b0);
    while (n < NPLAN) begin
      case ($urandom_range(0, 7))
        0: begin sign = 1'b0; mag = 1200 + $signed($urandom_range(0, 80)) - 40; end
        1: begin sign = 1'b1; mag = 160 + $signed($urandom_range(0, 80)) - 40; end
        7: begin sign = 1'($urandom_range(0, 1)); mag = 0; end
        default: begin sign = 1'($urandom_range(0, 1)); mag = int'($urandom_range(0, 2047)); end
      endcase
      m11 = 11'(mag);
      add_plan(n, {{5{sign}}, m11}, ($urandom_range(0, 4) == 0),
               ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 110)),
               ($urandom_range(0, 5) == 0));
      n++;
    end
    p_req_at[MID]       = -1;
    p_req_busy[MID]     = 1'b0;
    p_req_busy[MID - 1] = 1'b0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("por");
    @(negedge clk);
    #1 rst = 1'b0;

    guard    = 0;
    mid_done = 1'b0;
    while (m_idx < NPLAN && guard < BUDGET) begin
      @(negedge clk);
      guard++;
      if (!mid_done && m_idx == MID && m_busy && (cyc - m_start) == 20) begin
        #2 rst = 1'b1;
        req       = 1'b0;
        seen_busy = 1'b0;
        #1 chk_reset("mid");
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        mid_done = 1'b1;
        continue;
      end
      pi = (m_idx < NPLAN) ? m_idx : NPLAN - 1;
      if (req && req_ack) req = 1'b0;
      if (m_busy) begin
        bs = int'(cyc - m_start);
        if (p_bad[pi]) temp_data = (((bs / 2) % 2) == 1) ? (p_val[pi] ^ 16'h0001) : p_val[pi];
        else temp_data = p_val[pi];
        if (p_req_busy[pi] && bs == 5) req = 1'b1;
      end else if (!req && p_req_at[pi] >= 0 && int'(cyc - m_idle_ref) == p_req_at[pi]) begin
        req = 1'b1;
      end
    end
    if (guard >= BUDGET) begin
      checks++;
      failures++;
      $display("FAIL cycle_budget actual=%0d samples required=%0d", m_idx, NPLAN);
    end
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/temp_sched.md
# temp_sched

Measurement scheduler and alarm monitor for the DS18B20 driver. It owns the driver's reset line and runs each one-shot measurement:
- holds the driver idle between samples,
- releases it for one conversion window,
- captures the settled temperature word,
- converts it to two's complement and optionally averages it,
- raises high/low alarms with hysteresis.

It sits between `ds18b20_dri` and the display/host logic. It also gives the host an on-demand request/acknowledge port.

## Interface
- `PERIOD_CYC`, default 24_000_000: clk cycles spent in IDLE before an automatic sample (2 s at 12 MHz).
- `WINDOW_CYC`, default 7_200_000: clk cycles the driver runs before settle checking starts (600 ms).
- `STABLE_CYC`, default 64: consecutive equal `temp_data` cycles required to accept a sample.
- `TIMEOUT_CYC`, default 2_400_000: maximum SETTLE duration before the sample is declared failed.
- `TH_HI`, default 12'sd1200: high alarm threshold, signed, 1/16 °C (75.0 °C).
- `TH_LO`, default -12'sd160: low alarm threshold (-10.0 °C).
- `HYST`, default 12'd32: hysteresis (2.0 °C).

Ports:
- `clk` in 1: system clock, 12 MHz.
- `rst` in 1: asynchronous, active-high reset.
- `drv_rst_n` out 1: reset to `ds18b20_dri`; 0 holds the driver in reset.
- `temp_data` in 16: driver output word, `{sign x5, magnitude[10:0]}`.
- `req` in 1: level request for an immediate sample.
- `req_ack` out 1: one-cycle pulse when a request is accepted.
- `busy` out 1: high in RUN, SETTLE and CAPTURE.
- `temp_q` out 12: signed sample, or averaged sample when averaging is compiled in; 1/16 °C.
- `temp_valid` out 1: one-cycle strobe when `temp_q` updates.
- `alarm_hi` out 1: high-temperature alarm, level.
- `alarm_lo` out 1: low-temperature alarm, level.
- `err` out 1: sticky settle-timeout flag; cleared by the next successful capture.

## Operation
Reset values:
- `drv_rst_n` 0.
- All other outputs 0.
- State IDLE, all counters 0.

State machine:
- **IDLE**
  - `drv_rst_n` = 0; the period counter runs.
  - Leaves for RUN when the counter reaches `PERIOD_CYC-1` or when `req`=1.
  - On a `req`-caused exit, `req_ack` pulses in the transition cycle. If the period expiry and `req` coincide, one sample is taken and `req_ack` still pulses.
  - The period counter clears on exit.
- **RUN**
  - `drv_rst_n` = 1; the window counter runs.
  - At `WINDOW_CYC-1` the block goes to SETTLE.
- **SETTLE**
  - `temp_data` is registered each cycle (`prev`).
  - The stable counter increments when `temp_data == prev`; otherwise it clears to 0.
  - Stable counter reaching `STABLE_CYC-1` → CAPTURE.
  - Timeout counter reaching `TIMEOUT_CYC-1` → IDLE with `err` set. In that case there is no `temp_valid` and the alarms are unchanged.
- **CAPTURE**
  - One cycle; converts the sample and updates the averager and alarms.
  - Then → IDLE with `drv_rst_n` = 0.

Rules that apply in all states:
- `req` is ignored while `busy`; the requester holds `req` until it sees `req_ack`.
- Conversion: `s = sign ? -{1'b0,mag} : {1'b0,mag}`, 12-bit signed, where `sign = temp_data[15]`. Negative zero converts to 0.
- Alarm comparisons use `temp_q`, in signed arithmetic.
  - `alarm_hi` sets when `temp_q >= TH_HI` and clears when `temp_q < TH_HI-HYST`; between those points it holds.
  - `alarm_lo` sets when `temp_q <= TH_LO` and clears when `temp_q > TH_LO+HYST`.

## Timing
- `temp_valid`, `temp_q` and the alarm outputs all update together, registered, one cycle after CAPTURE.
- `err` clears in that same cycle.
- `req_ack` is registered and occurs in the same cycle the state register enters RUN.
- Nominal sample latency from `req`: 1 + `WINDOW_CYC` + `STABLE_CYC` + 2 cycles.
- An asynchronous `rst` mid-sample immediately forces `drv_rst_n` = 0 and all outputs to their reset values.

## Configuration
- `TEMP_SCHED_AVG_EN` defined:
  - `temp_q` is the mean of the last 4 samples.
  - 4-entry shift buffer, 14-bit signed sum, arithmetic shift right by 2, truncating toward -inf.
  - The first capture after reset primes all 4 entries with that sample.
  - A failed sample does not enter the buffer.
- `TEMP_SCHED_AVG_EN` undefined: `temp_q` = current converted sample; no buffer is built.

## Structure
- Package `temp_sched_pkg`:
  - state enum (IDLE, RUN, SETTLE, CAPTURE),
  - `TEMP_W` = 12,
  - `SUM_W` = 14,
  - the sign/magnitude conversion function.
- Sub-module `temp_hyst_cmp`: registered set/clear hysteresis comparator, with a parameter selecting high or low polarity. It is instantiated twice.

## Test plan
Use `PERIOD_CYC`=100, `WINDOW_CYC`=50, `STABLE_CYC`=4, `TIMEOUT_CYC`=40.
- **Reset:** after `rst` → `drv_rst_n`=0 and all outputs 0; the first auto sample starts 100 cycles after release.
- **Conversion:** `temp_data`=16'h0190 → `temp_q`=400 with one `temp_valid`. 16'hF8A0 (sign, mag 160) → `temp_q`=-160 and `alarm_lo`=1.
- **Hysteresis:** samples 1200, 1180, 1167 → `alarm_hi` reads 1, 1, 0.
- **Request:** `req` high in IDLE cycle 10 → `req_ack` pulses once and `busy` rises. `req` raised while `busy` → no ack until IDLE.
- **Timeout:** `temp_data` toggling every 2 cycles during SETTLE → `err`=1 after 40 cycles, no `temp_valid`, back to IDLE. A subsequent good sample clears `err`.
- **Averaging (`TEMP_SCHED_AVG_EN`):** samples 100, 200, 300, 400 → `temp_q` reads 100, 125, 175, 250.
